// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs four accepted bytes, big-endian, into a 32-bit word.
// Sampling is centred on each bit by first waiting half a bit period after the start edge.
module uart_rx_word #(
   parameter int unsigned CLKS_PER_BIT = 2604
) (
   input  logic        CLK,
   input  logic        INITIALIZE,
   input  logic        ENABLE,
   input  logic        UART_RX,
   output logic [7:0]  BYTE_DATA,
   output logic        BYTE_VALID,
   output logic [31:0] WORD_DATA,
   output logic        WORD_VALID,
   output logic        FRAME_ERR,
   output logic        BUSY
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    data, data_n;
   logic [1:0]    byte_cnt;
   logic [23:0]   word_buf;
   logic          rx_meta, rx_s;
   logic          byte_ok, frame_bad;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      idx_n     = idx;
      data_n    = data;
      byte_ok   = 1'b0;
      frame_bad = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (ENABLE && !rx_s) state_n = START;
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n = DATA;
                  idx_n   = '0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_n       = '0;
               data_n[idx] = rx_s;
               idx_n       = idx + 3'd1;
               if (idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
               if (rx_s) byte_ok = 1'b1;
               else      frame_bad = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (INITIALIZE) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         data       <= '0;
         byte_cnt   <= '0;
         word_buf   <= '0;
         BYTE_DATA  <= '0;
         BYTE_VALID <= 1'b0;
         WORD_DATA  <= '0;
         WORD_VALID <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         rx_meta    <= UART_RX;
         rx_s       <= rx_meta;
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         data       <= data_n;
         BYTE_VALID <= byte_ok;
         FRAME_ERR  <= frame_bad;
         WORD_VALID <= 1'b0;
         if (byte_ok) begin
            BYTE_DATA <= data;
            byte_cnt  <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0: word_buf[23:16] <= data;
               2'd1: word_buf[15:8]  <= data;
               2'd2: word_buf[7:0]   <= data;
               default: begin
                  WORD_DATA  <= {word_buf, data};
                  WORD_VALID <= 1'b1;
               end
            endcase
         end else if (state == IDLE && !ENABLE) begin
            // loader not requesting: drop any partially assembled word
            byte_cnt <= '0;
         end
      end
   end

   assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit; strobes are tallied by a
// negedge monitor and compared against hand-computed expectations.
module tb_uart_rx_word;

   logic        CLK = 1'b0;
   logic        INITIALIZE = 1'b1;
   logic        ENABLE = 1'b0;
   logic        UART_RX = 1'b1;
   logic [7:0]  BYTE_DATA;
   logic        BYTE_VALID;
   logic [31:0] WORD_DATA;
   logic        WORD_VALID;
   logic        FRAME_ERR;
   logic        BUSY;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int n_bv = 0, n_wv = 0, n_fe = 0, n_busy = 0;
   int n_overlap = 0, n_long = 0, n_wv_alone = 0;
   int bv_cyc = 0;
   logic prev_bv = 1'b0, prev_wv = 1'b0, prev_fe = 1'b0;
   int s_bv, s_wv, s_fe, s_busy, first_start, lat;

   uart_rx_word #(.CLKS_PER_BIT(16)) dut (
      .CLK        (CLK),
      .INITIALIZE (INITIALIZE),
      .ENABLE     (ENABLE),
      .UART_RX    (UART_RX),
      .BYTE_DATA  (BYTE_DATA),
      .BYTE_VALID (BYTE_VALID),
      .WORD_DATA  (WORD_DATA),
      .WORD_VALID (WORD_VALID),
      .FRAME_ERR  (FRAME_ERR),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (BYTE_VALID) begin
         n_bv++;
         bv_cyc = cyc;
      end
      if (WORD_VALID) n_wv++;
      if (FRAME_ERR) n_fe++;
      if (BUSY) n_busy++;
      if (BYTE_VALID && FRAME_ERR) n_overlap++;
      if (WORD_VALID && !BYTE_VALID) n_wv_alone++;
      if ((BYTE_VALID && prev_bv) || (WORD_VALID && prev_wv) || (FRAME_ERR && prev_fe)) n_long++;
      prev_bv = BYTE_VALID;
      prev_wv = WORD_VALID;
      prev_fe = FRAME_ERR;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // every stimulus step ends 1 time unit after a rising edge
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      UART_RX = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         UART_RX = b[i];
         tick(16);
      end
      UART_RX = stop;
      tick(16);
      UART_RX = 1'b1;
   endtask

   task automatic snap();
      s_bv = n_bv;
      s_wv = n_wv;
      s_fe = n_fe;
      s_busy = n_busy;
   endtask

   initial begin
      tick(3);
      check("rst_byte_data", 32'(BYTE_DATA), 32'h00);
      check("rst_word_data", WORD_DATA, 32'h0000_0000);
      check("rst_strobes", {29'd0, BYTE_VALID, WORD_VALID, FRAME_ERR}, 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      INITIALIZE = 1'b0;
      tick(5);

      // four good bytes form one word
      ENABLE = 1'b1;
      snap();
      send(8'h20, 1'b1); tick(5);
      send(8'h01, 1'b1); tick(5);
      send(8'h00, 1'b1); tick(5);
      send(8'h05, 1'b1); tick(5);
      check("w1_bv_count", 32'(n_bv - s_bv), 32'd4);
      check("w1_wv_count", 32'(n_wv - s_wv), 32'd1);
      check("w1_word", WORD_DATA, 32'h2001_0005);
      check("w1_byte", 32'(BYTE_DATA), 32'h05);

      // framing error neither delivers nor counts the byte
      snap();
      send(8'hA5, 1'b0); tick(20);
      check("fe_count", 32'(n_fe - s_fe), 32'd1);
      check("fe_no_bv", 32'(n_bv - s_bv), 32'd0);
      check("fe_hold_byte", 32'(BYTE_DATA), 32'h05);
      send(8'h11, 1'b1); tick(5);
      send(8'h22, 1'b1); tick(5);
      send(8'h33, 1'b1); tick(5);
      send(8'h44, 1'b1); tick(5);
      check("w2_word", WORD_DATA, 32'h1122_3344);
      check("w2_wv_count", 32'(n_wv - s_wv), 32'd1);
      check("w2_fe_total", 32'(n_fe - s_fe), 32'd1);

      // short low glitch is rejected at mid start bit
      snap();
      UART_RX = 1'b0; tick(4);
      UART_RX = 1'b1; tick(30);
      check("gl_busy_seen", 32'((n_busy - s_busy) > 0), 32'd1);
      check("gl_no_bv", 32'(n_bv - s_bv), 32'd0);
      check("gl_no_fe", 32'(n_fe - s_fe), 32'd0);

      // dropping ENABLE in IDLE discards the partial word
      snap();
      send(8'h12, 1'b1); tick(5);
      send(8'h34, 1'b1); tick(5);
      ENABLE = 1'b0; tick(5);
      ENABLE = 1'b1; tick(2);
      send(8'hDE, 1'b1); tick(5);
      send(8'hAD, 1'b1); tick(5);
      send(8'hBE, 1'b1); tick(5);
      send(8'hEF, 1'b1); tick(5);
      check("w3_word", WORD_DATA, 32'hDEAD_BEEF);
      check("w3_wv_count", 32'(n_wv - s_wv), 32'd1);
      check("w3_bv_count", 32'(n_bv - s_bv), 32'd6);
      ENABLE = 1'b0;
      snap();
      send(8'h3C, 1'b1); tick(20);
      check("dis_no_bv", 32'(n_bv - s_bv), 32'd0);
      check("dis_no_fe", 32'(n_fe - s_fe), 32'd0);
      check("dis_no_busy", 32'(n_busy - s_busy), 32'd0);
      check("dis_hold_byte", 32'(BYTE_DATA), 32'hEF);

      // reset during bit 4 of 0x7E
      ENABLE = 1'b1;
      tick(2);
      snap();
      UART_RX = 1'b0; tick(16);
      for (int i = 0; i < 4; i++) begin
         UART_RX = (i == 0) ? 1'b0 : 1'b1;
         tick(16);
      end
      UART_RX = 1'b1; tick(8);
      check("mid_busy_before_rst", 32'(BUSY), 32'd1);
      INITIALIZE = 1'b1; tick(2);
      check("mid_rst_byte", 32'(BYTE_DATA), 32'h00);
      check("mid_rst_word", WORD_DATA, 32'h0);
      check("mid_rst_busy", 32'(BUSY), 32'd0);
      check("mid_rst_strobes", {29'd0, BYTE_VALID, WORD_VALID, FRAME_ERR}, 32'd0);
      INITIALIZE = 1'b0; tick(100);
      check("mid_no_bv", 32'(n_bv - s_bv), 32'd0);
      check("mid_no_fe", 32'(n_fe - s_fe), 32'd0);
      send(8'h55, 1'b1); tick(5);
      check("mid_next_byte", 32'(BYTE_DATA), 32'h55);
      check("mid_next_bv", 32'(n_bv - s_bv), 32'd1);

      // back-to-back frames; latency measured on the first
      ENABLE = 1'b0; tick(3);
      ENABLE = 1'b1; tick(2);
      snap();
      first_start = cyc;
      send(8'hFF, 1'b1);
      lat = bv_cyc - first_start;
      check("lat_first_bv", 32'(n_bv - s_bv), 32'd1);
      check("lat_window", 32'((lat >= 154) && (lat <= 156)), 32'd1);
      send(8'h00, 1'b1);
      send(8'h80, 1'b1);
      send(8'h01, 1'b1);
      tick(5);
      check("b2b_word", WORD_DATA, 32'hFF00_8001);
      check("b2b_bv_count", 32'(n_bv - s_bv), 32'd4);
      check("b2b_byte", 32'(BYTE_DATA), 32'h01);

      check("strobe_overlap", 32'(n_overlap), 32'd0);
      check("strobe_width", 32'(n_long), 32'd0);
      check("wv_without_bv", 32'(n_wv_alone), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 2604, meaning clock cycles per UART bit period (minimum 4).
REQ-002 SHALL have port CLK  input  1  single system clock; all logic is on its rising edge.
REQ-003 SHALL have port INITIALIZE  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port ENABLE  input  1  frame reception permitted (driven by the loader's load-request).
REQ-005 SHALL have port UART_RX  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port BYTE_DATA  output  8  last received byte.
REQ-007 SHALL have port BYTE_VALID  output  1  one-cycle strobe, BYTE_DATA is new.
REQ-008 SHALL have port WORD_DATA  output  32  last assembled instruction word.
REQ-009 SHALL have port WORD_VALID  output  1  one-cycle strobe, WORD_DATA is new.
REQ-010 SHALL have port FRAME_ERR  output  1  one-cycle strobe, stop bit sampled low.
REQ-011 SHALL have port BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass UART_RX through a two-flop synchronizer before use; the synchronized line is rx_s; the synchronizer presets to 1.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-period counter cnt and a bit index 0..7.
REQ-014 In IDLE with ENABLE=1 and rx_s=0, SHALL go to START with cnt=0; with ENABLE=0 it SHALL stay in IDLE regardless of rx_s.
REQ-015 In START, when cnt = CLKS_PER_BIT/2-1: rx_s=0 -> DATA, cnt=0, index=0; rx_s=1 -> IDLE (glitch rejected, no strobe).
REQ-016 In DATA, when cnt = CLKS_PER_BIT-1, SHALL sample rx_s into bit [index] (LSB first), clear cnt, and after index 7 go to STOP.
REQ-017 In STOP, when cnt = CLKS_PER_BIT-1: rx_s=1 -> update BYTE_DATA and pulse BYTE_VALID; rx_s=0 -> pulse FRAME_ERR and discard the byte; both -> IDLE.
REQ-018 Strobes SHALL be high for exactly one cycle; BYTE_VALID and FRAME_ERR SHALL never be high together.
REQ-019 Accepted bytes SHALL be packed big-endian: byte 0 -> WORD_DATA[31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-020 On the 4th accepted byte, WORD_DATA SHALL update and WORD_VALID SHALL pulse in the same cycle as that BYTE_VALID; the byte counter SHALL wrap to 0.
REQ-021 A framing error SHALL NOT advance or clear the byte counter; partial word bytes are retained.
REQ-022 ENABLE deasserted mid-frame SHALL NOT abort the frame; the frame completes and is delivered normally.
REQ-023 While in IDLE with ENABLE=0, the byte counter SHALL be held at 0, discarding any partial word.
REQ-024 WORD_DATA and BYTE_DATA SHALL hold their values between strobes.
REQ-025 Latency SHALL be: BYTE_VALID asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (+/-1) after the UART_RX falling edge of the start bit.

Reset
REQ-026 On INITIALIZE=1 at a clock edge, SHALL set state to IDLE, clear cnt, index, and byte counter, and preset the synchronizer to 1.
REQ-027 Reset values SHALL be BYTE_DATA=0x00, WORD_DATA=0x00000000, and BYTE_VALID=WORD_VALID=FRAME_ERR=BUSY=0.
REQ-028 Reset mid-frame SHALL abandon the frame and produce no strobe; reception resumes on the next start bit after release.
REQ-029 INITIALIZE SHALL take priority over all other inputs.

Verification (bench uses CLKS_PER_BIT=16)
REQ-030 With ENABLE=1, send bytes 0x20,0x01,0x00,0x05 -> four BYTE_VALID pulses; WORD_VALID once, with WORD_DATA=0x20010005.
REQ-031 Send 0xA5 with stop bit 0, then 0x11,0x22,0x33,0x44 -> FRAME_ERR once; WORD_DATA=0x11223344.
REQ-032 Send a 4-cycle low glitch on UART_RX -> BUSY pulses; no BYTE_VALID and no FRAME_ERR.
REQ-033 Send 0x12,0x34, drop ENABLE in IDLE, raise it, send 0xDE,0xAD,0xBE,0xEF -> WORD_DATA=0xDEADBEEF; a frame started with ENABLE=0 -> no strobes.
REQ-034 Assert INITIALIZE during bit 4 of byte 0x7E -> no strobe; all outputs at reset values; next byte 0x55 -> BYTE_DATA=0x55.
REQ-035 Send bytes back to back (stop bit immediately followed by start bit) 0xFF,0x00,0x80,0x01 -> WORD_DATA=0xFF008001; check the REQ-025 latency on the first byte.
